// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide sequencer.
// Operation codes match the ALU's alu_ops field.
// ITER is the default operand width, and so the number of iterations per operation.
package muldiv_pkg;

    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;
    localparam logic [3:0] OP_REM = 4'b1110;

    localparam int ITER = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes; purely combinational.
// The quotient register shifts the next dividend bit out of its MSB and the new quotient bit into its LSB.
// The remainder is restored (kept as the shifted value) whenever the trial subtract borrows.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_dvsr,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    logic [W:0] w_shift;
    logic [W:0] w_diff;

    // Shift the remainder left, pull in the next dividend bit, then do the trial subtract
    assign w_shift = {i_rem, i_quo[W-1]};
    assign w_diff  = w_shift - {1'b0, i_dvsr};

    // A borrow (MSB set) means the divisor did not fit: keep the shifted remainder, quotient bit 0
    assign o_rem = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
    assign o_quo = {i_quo[W-2:0], ~w_diff[W]};

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply / signed divide sequencer. Macro MULDIV_REM_EN adds signed remainder (op 4'b1110).
// Latency in edges, acceptance edge included: mul 33, div 34, special cases and unsupported ops 1.
// Accepts only in IDLE; the result is held in DONE with stable data until resp_ready is seen.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W = ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    // r_x: product accumulator / remainder; r_y: multiplier / dividend-then-quotient;
    // r_z: multiplicand / divisor magnitude
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_z;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_rem_sel;
    logic              r_resp_valid;
    logic              r_busy;
    logic              r_req_ready;

    logic              w_req_rem;
    logic              w_req_div;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [DATA_W-1:0] w_spec_val;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [DATA_W-1:0] w_acc_nxt;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_quo_nxt;
    logic [DATA_W-1:0] w_quo_fix;
    logic [DATA_W-1:0] w_rem_fix;

`ifdef MULDIV_REM_EN
    assign w_req_rem = (req_op == OP_REM);
`else
    assign w_req_rem = 1'b0;
`endif

    // Divide-class requests and the two cases that bypass the iteration loop
    assign w_req_div  = (req_op == OP_DIV) || w_req_rem;
    assign w_div_zero = (req_b == '0);
    assign w_div_ovf  = (req_a == MIN_NEG) && (req_b == '1);
    assign w_spec_val = w_req_rem ? (w_div_zero ? req_a : '0)
                                  : (w_div_zero ? '1 : MIN_NEG);

    assign w_abs_a = req_a[DATA_W-1] ? -req_a : req_a;
    assign w_abs_b = req_b[DATA_W-1] ? -req_b : req_b;

    // Shift-add: fold in the multiplicand when the current multiplier bit is set
    assign w_acc_nxt = r_y[0] ? (r_x + r_z) : r_x;

    // Sign restoration: quotient negative when operand signs differ, remainder follows the dividend
    assign w_quo_fix = r_neg_q ? -r_y : r_y;
    assign w_rem_fix = r_neg_r ? -r_x : r_x;

    div_step #(
        .W (DATA_W)
    ) u_div_step (
        .i_rem  (r_x),
        .i_quo  (r_y),
        .i_dvsr (r_z),
        .o_rem  (w_rem_nxt),
        .o_quo  (w_quo_nxt)
    );

    // Sequencer FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_resp_data  <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_rem_sel    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_req_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_x         <= '0;
                        r_neg_q     <= req_a[DATA_W-1] ^ req_b[DATA_W-1];
                        r_neg_r     <= req_a[DATA_W-1];
                        r_rem_sel   <= w_req_rem;
                        if (req_op == OP_MUL) begin
                            r_y     <= req_b;
                            r_z     <= req_a;
                            r_state <= MUL;
                        end else if (w_req_div && !w_div_zero && !w_div_ovf) begin
                            r_y     <= w_abs_a;
                            r_z     <= w_abs_b;
                            r_state <= DIV;
                        end else begin
                            // Special divide cases and unsupported ops answer straight away
                            r_resp_data  <= w_req_div ? w_spec_val : '0;
                            r_resp_valid <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                end
                MUL: begin
                    r_x   <= w_acc_nxt;
                    r_y   <= r_y >> 1;
                    r_z   <= r_z << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_resp_data  <= w_acc_nxt;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DIV: begin
                    r_x   <= w_rem_nxt;
                    r_y   <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_resp_data  <= r_rem_sel ? w_rem_fix : w_quo_fix;
                    r_resp_valid <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign busy       = r_busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
// Latency is counted in rising edges, acceptance edge included, until resp_valid is seen.
// Also covers output hold under backpressure, ignored requests while busy, and async reset mid-divide.
module tb_muldiv_sequencer;

    localparam logic [3:0] T_MUL = 4'b1100;
    localparam logic [3:0] T_DIV = 4'b1101;
    localparam logic [3:0] T_REM = 4'b1110;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int n_total;
    int n_bad;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rem_supported();
`ifdef MULDIV_REM_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference result from plain signed arithmetic
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (op == T_MUL) return a * b;
        if (op == T_DIV) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
        end
        if (op == T_REM && rem_supported()) begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
        end
        return 32'd0;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == T_MUL) return 33;
        if (op == T_DIV || (op == T_REM && rem_supported())) begin
            if (b == 32'd0) return 1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        return 1;
    endfunction

    // Issue one request, track latency and busy, then hold the response for `hold` cycles before taking it
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_d;
        logic [31:0] held;
        int          exp_lat;
        int          edges;
        exp_d   = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        @(negedge clk);
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        edges = 1;
        while (!resp_valid && edges < 120) begin
            check_eq("busy_inflight", {31'd0, busy}, 32'd1);
            check_eq("req_ready_inflight", {31'd0, req_ready}, 32'd0);
            req_valid = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            edges++;
        end
        check_eq("latency", 32'(edges), 32'(exp_lat));
        if (!resp_valid) begin
            $display("FAIL resp_timeout: got=no_resp expected=resp_valid op=%h", op);
            n_total++;
            n_bad++;
            return;
        end
        check_eq("resp_data", resp_data, exp_d);
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            resp_ready = 1'b0;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            check_eq("hold_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("hold_data", resp_data, held);
            check_eq("hold_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_eq("taken_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("taken_busy", {31'd0, busy}, 32'd0);
        check_eq("taken_data_held", resp_data, held);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          r;
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 4'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b0;
        #12;
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(T_MUL, 32'd7, 32'd6, 0);
        run_op(T_DIV, 32'hFFFF_FFEC, 32'd3, 1);
        run_op(T_DIV, 32'd20, 32'hFFFF_FFFD, 0);
        run_op(T_DIV, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 0);
        run_op(T_DIV, 32'd123, 32'd0, 0);
        run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
        run_op(4'b0010, 32'd55, 32'd66, 0);
        run_op(T_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(T_REM, 32'd9, 32'd0, 0);
        run_op(T_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Async reset in the middle of a divide drops it without a response
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = T_DIV;
        req_a     = 32'd1000;
        req_b     = 32'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("midrst_resp_data", resp_data, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op(T_MUL, 32'd3, 32'd5, 0);

        // Randomized mix of ops and operand ranges
        for (int k = 0; k < 50; k++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 200)) - 32'd100;
            if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 40)) - 32'd20;
            if (r <= 3)      op = T_MUL;
            else if (r <= 6) op = T_DIV;
            else if (r == 7) op = T_REM;
            else if (r == 8) op = 4'($urandom);
            else begin
                op = ($urandom_range(0, 1) == 1) ? T_DIV : T_REM;
                if ($urandom_range(0, 1) == 1) b = 32'd0;
                else begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
            end
            run_op(op, a, b, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
